// File: rtl/ds_pkg.sv
// Shared sizing helpers, FSM state type and tile coordinate decode for block_downsampler.
package ds_pkg;

  typedef enum logic {
    ST_UNSYNCED = 1'b0,
    ST_RUN      = 1'b1
  } ds_state_e;

  // Field widths cover the widest legal tile (LOG2_BLK up to 4).
  typedef struct packed {
    logic [10:0] ox;
    logic [9:0]  oy;
    logic [3:0]  hl;
    logic [3:0]  vl;
  } tile_coord_t;

  function automatic int ds_out_w(input int in_w, input int log2_blk);
    return in_w >> log2_blk;
  endfunction

  function automatic int ds_out_h(input int in_h, input int log2_blk);
    return in_h >> log2_blk;
  endfunction

  function automatic int ds_addr_w(input int out_w, input int out_h);
    return (out_w * out_h > 1) ? $clog2(out_w * out_h) : 1;
  endfunction

  // Wide enough for (2^pix_w - 1) * BLK^2 without overflow.
  function automatic int ds_sum_w(input int pix_w, input int log2_blk);
    return pix_w + 2 * log2_blk;
  endfunction

  function automatic tile_coord_t ds_tile_coord(input logic [10:0] h, input logic [9:0] v,
                                                input int log2_blk);
    tile_coord_t t;
    logic [10:0] mh;
    logic [9:0]  mv;
    mh   = 11'((1 << log2_blk) - 1);
    mv   = 10'((1 << log2_blk) - 1);
    t.ox = h >> log2_blk;
    t.oy = v >> log2_blk;
    t.hl = 4'(h & mh);
    t.vl = 4'(v & mv);
    return t;
  endfunction

endpackage

// File: rtl/ds_line_acc.sv
// Per-column tile accumulator: DEPTH x SUM_W RAM with registered read and an
// overwrite-or-add write port that adds onto the previously read word.
module ds_line_acc #(
  parameter int DEPTH = 80,
  parameter int SUM_W = 9,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [SUM_W-1:0] o_rd_data,
  input  logic             i_wr_en,
  input  logic             i_wr_add,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [SUM_W-1:0] i_wr_data
);

  logic [SUM_W-1:0] r_mem [DEPTH];
  logic [SUM_W-1:0] r_rd_data;

  // The add path relies on the read of the same entry having been issued earlier in the row.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_add ? (r_rd_data + i_wr_data) : i_wr_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/block_downsampler.sv
// Tile-average downsampler: BLKxBLK grayscale tiles -> thresholded bitmap writes.
// Optional DS_FRAME_STATS_EN adds set_count_out (count of 1-tiles of the last frame).
//
//  state       | meaning
//  ST_UNSYNCED | no frame start seen since reset; pixels ignored
//  ST_RUN      | locked to raster; tiles accumulated and emitted
module block_downsampler
  import ds_pkg::*;
#(
  parameter int PIX_W    = 5,
  parameter int LOG2_BLK = 2,
  parameter int IN_W     = 320,
  parameter int IN_H     = 240,
  localparam int OUT_W   = ds_out_w(IN_W, LOG2_BLK),
  localparam int OUT_H   = ds_out_h(IN_H, LOG2_BLK),
  localparam int ADDR_W  = ds_addr_w(OUT_W, OUT_H)
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              pixel_valid_in,
  input  logic [PIX_W-1:0]  pixel_in,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic [PIX_W-1:0]  thresh_in,
  input  logic              invert_in,
  output logic              bit_valid_out,
  output logic              bit_out,
  output logic [PIX_W-1:0]  avg_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic              frame_done_out
`ifdef DS_FRAME_STATS_EN
  , output logic [ADDR_W:0] set_count_out
`endif
);

  localparam int BLK   = 1 << LOG2_BLK;
  localparam int SUM_W = ds_sum_w(PIX_W, LOG2_BLK);
  localparam int LB_AW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [3:0] LAST_L = 4'(BLK - 1);

  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  // Async assert, synchronous release for everything downstream.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_rst_sync <= '0;
    else           r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  ds_state_e          r_state;
  logic [PIX_W-1:0]   r_thresh;
  logic               r_invert;
  logic [SUM_W-1:0]   r_run_sum;
  logic               r_s1_valid;
  logic               r_s1_last;
  logic [SUM_W-1:0]   r_s1_sum;
  logic [ADDR_W-1:0]  r_s1_addr;

  tile_coord_t        w_tc;
  logic               w_in_range, w_origin, w_act, w_row_end, w_tile_end;
  logic [SUM_W-1:0]   w_row_sum, w_tile_sum, w_lb_rd;
  logic [ADDR_W-1:0]  w_addr;
  logic [PIX_W-1:0]   w_avg;
  logic               w_bit;

  assign w_tc       = ds_tile_coord(hcount_in, vcount_in, LOG2_BLK);
  assign w_in_range = (int'(hcount_in) < OUT_W * BLK) && (int'(vcount_in) < OUT_H * BLK);
  assign w_origin   = pixel_valid_in && (hcount_in == 11'd0) && (vcount_in == 10'd0);
  assign w_act      = pixel_valid_in && w_in_range && ((r_state == ST_RUN) || w_origin);
  assign w_row_end  = w_act && (w_tc.hl == LAST_L);
  assign w_tile_end = w_row_end && (w_tc.vl == LAST_L);
  assign w_row_sum  = ((w_tc.hl == 4'd0) ? '0 : r_run_sum) + SUM_W'(pixel_in);
  assign w_tile_sum = w_lb_rd + w_row_sum;
  assign w_addr     = ADDR_W'(int'(w_tc.oy) * OUT_W + int'(w_tc.ox));
  assign w_avg      = PIX_W'(r_s1_sum >> (2 * LOG2_BLK));
  assign w_bit      = (w_avg >= r_thresh) ^ r_invert;

  ds_line_acc #(.DEPTH(OUT_W), .SUM_W(SUM_W)) u_line_acc (
    .i_clk     (clk_in),
    .i_rst_n   (w_rst_n),
    .i_rd_en   (w_act && (w_tc.hl == 4'd0)),
    .i_rd_addr (w_tc.ox[LB_AW-1:0]),
    .o_rd_data (w_lb_rd),
    .i_wr_en   (w_row_end),
    .i_wr_add  (w_tc.vl != 4'd0),
    .i_wr_addr (w_tc.ox[LB_AW-1:0]),
    .i_wr_data (w_row_sum)
  );

  always_ff @(posedge clk_in or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state        <= ST_UNSYNCED;
      r_thresh       <= '0;
      r_invert       <= 1'b0;
      r_run_sum      <= '0;
      r_s1_valid     <= 1'b0;
      r_s1_last      <= 1'b0;
      r_s1_sum       <= '0;
      r_s1_addr      <= '0;
      bit_valid_out  <= 1'b0;
      bit_out        <= 1'b0;
      avg_out        <= '0;
      addr_out       <= '0;
      frame_done_out <= 1'b0;
    end else begin
      case (r_state)
        ST_UNSYNCED: if (w_origin) r_state <= ST_RUN;
        default:     r_state <= ST_RUN;
      endcase
      if (w_origin) begin
        r_thresh <= thresh_in;
        r_invert <= invert_in;
      end
      if (w_act) r_run_sum <= w_row_sum;
      // Stage 1: capture the finished tile sum and its address.
      r_s1_valid <= w_tile_end;
      if (w_tile_end) begin
        r_s1_sum  <= w_tile_sum;
        r_s1_addr <= w_addr;
        r_s1_last <= (int'(w_tc.ox) == OUT_W - 1) && (int'(w_tc.oy) == OUT_H - 1);
      end
      // Stage 2: average, threshold and strobe.
      bit_valid_out  <= r_s1_valid;
      frame_done_out <= r_s1_valid && r_s1_last;
      if (r_s1_valid) begin
        avg_out  <= w_avg;
        bit_out  <= w_bit;
        addr_out <= r_s1_addr;
      end
    end
  end

`ifdef DS_FRAME_STATS_EN
  logic [ADDR_W:0] r_ones;
  logic [ADDR_W:0] w_cnt_next;

  // Tile 0 opens a new count, so an aborted frame never leaks into the next one.
  assign w_cnt_next = ((r_s1_addr == '0) ? '0 : r_ones) + {{ADDR_W{1'b0}}, w_bit};

  always_ff @(posedge clk_in or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_ones        <= '0;
      set_count_out <= '0;
    end else if (r_s1_valid) begin
      r_ones <= w_cnt_next;
      if (r_s1_last) set_count_out <= w_cnt_next;
    end
  end
`endif

endmodule

// File: tb/tb_block_downsampler.sv
// Scoreboard bench for block_downsampler on a reduced 34x18 frame (8x4 tiles plus ignored margin).
module tb_block_downsampler;

  localparam int PIX_W = 5, LOG2_BLK = 2, BLK = 4;
  localparam int IN_W = 34, IN_H = 18, OUT_W = 8, OUT_H = 4, NT = 32, ADDR_W = 5;
  localparam int FR = IN_W * IN_H;

  logic clk = 1'b0, rst_n = 1'b0, pv = 1'b0, inv = 1'b0;
  logic [PIX_W-1:0] pix = '0, thr = '0;
  logic [10:0] hc = '0;
  logic [9:0]  vc = '0;
  logic bv, bo, fd;
  logic [PIX_W-1:0]  avg;
  logic [ADDR_W-1:0] addr;
`ifdef DS_FRAME_STATS_EN
  logic [ADDR_W:0] setc;
`endif

  block_downsampler #(.PIX_W(PIX_W), .LOG2_BLK(LOG2_BLK), .IN_W(IN_W), .IN_H(IN_H)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .pixel_valid_in(pv), .pixel_in(pix),
    .hcount_in(hc), .vcount_in(vc), .thresh_in(thr), .invert_in(inv),
    .bit_valid_out(bv), .bit_out(bo), .avg_out(avg), .addr_out(addr),
    .frame_done_out(fd)
`ifdef DS_FRAME_STATS_EN
    , .set_count_out(setc)
`endif
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { int addr; int avg; bit b; bit last; int cnt; int cyc; } exp_t;
  exp_t q[$];
  int errors = 0, checks = 0;
  int img[IN_H][IN_W];
  bit m_synced = 0, m_inv = 0;
  int m_thresh = 0, m_ones = 0;
  int obs_addr[$], obs_avg[$];
  bit obs_bit[$];
  int fd_count = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: tile average by plain summation over the stored image.
  task automatic push_tile(input int ox, input int oy);
    exp_t e;
    int sum = 0;
    for (int i = 0; i < BLK; i++)
      for (int j = 0; j < BLK; j++) sum += img[oy*BLK+i][ox*BLK+j];
    e.avg  = sum / (BLK * BLK);
    e.b    = (e.avg >= m_thresh) ^ m_inv;
    m_ones += int'(e.b);
    e.addr = oy * OUT_W + ox;
    e.last = (e.addr == NT - 1);
    e.cnt  = m_ones;
    e.cyc  = cyc + 2;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bv) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_strobe: got addr %0d expected no strobe (cycle %0d)", addr, cyc);
      end else begin
        e = q.pop_front();
        check("addr", int'(addr), e.addr);
        check("avg", int'(avg), e.avg);
        check("bit", int'(bo), int'(e.b));
        check("frame_done", int'(fd), int'(e.last));
        check("latency", cyc, e.cyc);
`ifdef DS_FRAME_STATS_EN
        if (e.last) check("set_count", int'(setc), e.cnt);
`endif
      end
      obs_addr.push_back(int'(addr)); obs_avg.push_back(int'(avg)); obs_bit.push_back(bo);
      if (fd) fd_count++;
    end else if (fd) begin
      checks++; errors++;
      $display("FAIL frame_done_alone: got 1 expected 0 (cycle %0d)", cyc);
    end
  end

  task automatic idle();
    @(posedge clk); #1;
    pv = 1'b0; hc = '0; vc = '0; pix = PIX_W'($urandom);
  endtask

  task automatic px(input int h, input int v, input int p);
    @(posedge clk); #1;
    pv = 1'b1; hc = 11'(h); vc = 10'(v); pix = PIX_W'(p);
    if (h == 0 && v == 0) begin
      m_synced = 1; m_thresh = int'(thr); m_inv = inv; m_ones = 0;
    end
    if (m_synced && h < OUT_W*BLK && v < OUT_H*BLK && h % BLK == BLK-1 && v % BLK == BLK-1)
      push_tile(h / BLK, v / BLK);
  endtask

  task automatic drive_span(input int i0, input int i1, input int gap);
    for (int i = i0; i < i1; i++) begin
      int k = 0;
      while (gap > 0 && k < 3 && $urandom_range(99) < gap) begin idle(); k++; end
      px(i % IN_W, i / IN_W, img[i / IN_W][i % IN_W]);
    end
    idle();
  endtask

  task automatic drain();
    int n = 0;
    idle();
    while (q.size() != 0 && n < 50) begin @(posedge clk); n++; end
    repeat (3) @(posedge clk);
    check("drain_queue_empty", q.size(), 0);
  endtask

  task automatic clear_obs();
    obs_addr.delete(); obs_avg.delete(); obs_bit.delete(); fd_count = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0; m_synced = 0; q.delete();
    repeat (2) @(negedge clk);
    check("rst_bit_valid", int'(bv), 0);
    check("rst_bit", int'(bo), 0);
    check("rst_avg", int'(avg), 0);
    check("rst_addr", int'(addr), 0);
    check("rst_frame_done", int'(fd), 0);
`ifdef DS_FRAME_STATS_EN
    check("rst_set_count", int'(setc), 0);
`endif
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic fill_random();
    for (int v = 0; v < IN_H; v++)
      for (int h = 0; h < IN_W; h++) img[v][h] = int'($urandom_range(31));
  endtask

  initial begin
    int a_addr[$];
    bit a_bit[$];
    int n;
    do_reset();

    // 1: flat full-scale frame
    for (int v = 0; v < IN_H; v++) for (int h = 0; h < IN_W; h++) img[v][h] = 31;
    thr = 5'd16; inv = 1'b0; clear_obs();
    drive_span(0, FR, 0); drain();
    check("t1_strobes", obs_bit.size(), NT);
    n = 0; foreach (obs_bit[i]) if (obs_bit[i] && obs_avg[i] == 31 && obs_addr[i] == i) n++;
    check("t1_all_ones_in_order", n, NT);
    check("t1_frame_done_count", fd_count, 1);

    // 2: left half dark, right half bright, inverted
    for (int v = 0; v < IN_H; v++) for (int h = 0; h < IN_W; h++) img[v][h] = (h < OUT_W*BLK/2) ? 0 : 31;
    inv = 1'b1; clear_obs();
    drive_span(0, FR, 0); drain();
    n = 0; foreach (obs_bit[i]) if (obs_bit[i] == ((obs_addr[i] % OUT_W) < OUT_W/2)) n++;
    check("t2_halves", n, NT);

    // 3: ramp in tile 0; threshold changed mid-frame must not take effect
    fill_random();
    for (int v = 0; v < BLK; v++) for (int h = 0; h < BLK; h++) img[v][h] = v*BLK + h;
    inv = 1'b0; thr = 5'd8; clear_obs();
    drive_span(0, IN_W, 0); thr = 5'd0; drive_span(IN_W, FR, 0); drain();
    check("t3_strobes_a", obs_bit.size(), NT);
    check("t3_avg_tile0", obs_avg.size() > 0 ? obs_avg[0] : -1, 7);
    check("t3_bit_thr8", obs_bit.size() > 0 ? int'(obs_bit[0]) : -1, 0);
    thr = 5'd7; clear_obs();
    drive_span(0, IN_W, 0); thr = 5'd31; drive_span(IN_W, FR, 0); drain();
    check("t3_bit_thr7", obs_bit.size() > 0 ? int'(obs_bit[0]) : -1, 1);

    // 4: same image back-to-back and with gaps
    fill_random(); thr = 5'(15); inv = 1'b0; clear_obs();
    drive_span(0, FR, 0); drain();
    a_addr = obs_addr; a_bit = obs_bit; clear_obs();
    drive_span(0, FR, 50); drain();
    check("t4_len", obs_bit.size(), a_bit.size());
    n = 0; foreach (a_bit[i]) if (i < obs_bit.size() && (a_bit[i] != obs_bit[i] || a_addr[i] != obs_addr[i])) n++;
    check("t4_seq_diffs", n, 0);

    // 5: reset mid-row 5, frame resumes without origin
    fill_random(); clear_obs();
    drive_span(0, 5*IN_W + 10, 0); drain();
    do_reset(); clear_obs();
    drive_span(5*IN_W + 10, FR, 20); drain();
    check("t5_silent_after_reset", obs_bit.size(), 0);
    fill_random(); thr = 5'(20); clear_obs();
    drive_span(0, FR, 0); drain();
    check("t5_next_frame_strobes", obs_bit.size(), NT);

    // mid-frame origin aborts the partial frame
    fill_random(); clear_obs();
    drive_span(0, 10*IN_W + 7, 0);
    fill_random(); thr = 5'(12); inv = 1'b1;
    drive_span(0, FR, 0); drain();
    check("abort_strobes", obs_bit.size(), 2*OUT_W + NT);
    check("abort_frame_done", fd_count, 1);

`ifdef DS_FRAME_STATS_EN
    // 6: checkerboard of tiles
    for (int v = 0; v < IN_H; v++)
      for (int h = 0; h < IN_W; h++) img[v][h] = (((h/BLK) + (v/BLK)) % 2 == 0) ? 31 : 0;
    thr = 5'd16; inv = 1'b0; clear_obs();
    drive_span(0, FR, 30); drain();
    check("t6_set_count", int'(setc), NT/2);
`endif

    // random frames
    for (int f = 0; f < 2; f++) begin
      fill_random(); thr = 5'($urandom_range(31)); inv = 1'($urandom); clear_obs();
      drive_span(0, FR, 30); drain();
      check("rand_strobes", obs_bit.size(), NT);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
